// File: rtl/slc3_test_top.sv
// Reduced SLC-3 CPU with 256-word RAM, switch/hex memory-mapped I/O and 7-segment drivers.
// Define DEBUG_HEX_EN to show PC[7:0] on HEX5:HEX4; otherwise those digits are blank.
module slc3_test_top #(
  parameter int          MEM_WORDS = 256,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [9:0] SW,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

  localparam logic [4:0] S_HALTED = 5'd0;
  localparam logic [4:0] S_FETCH1 = 5'd1;
  localparam logic [4:0] S_FETCH2 = 5'd2;
  localparam logic [4:0] S_FETCH3 = 5'd3;
  localparam logic [4:0] S_DECODE = 5'd4;
  localparam logic [4:0] S_ADD    = 5'd5;
  localparam logic [4:0] S_AND    = 5'd6;
  localparam logic [4:0] S_NOT    = 5'd7;
  localparam logic [4:0] S_BR     = 5'd8;
  localparam logic [4:0] S_JMP    = 5'd9;
  localparam logic [4:0] S_LDR1   = 5'd10;
  localparam logic [4:0] S_LDR2   = 5'd11;
  localparam logic [4:0] S_LDR3   = 5'd12;
  localparam logic [4:0] S_STR1   = 5'd13;
  localparam logic [4:0] S_STR2   = 5'd14;
  localparam logic [4:0] S_PAUSE  = 5'd15;
  localparam logic [4:0] S_PWAIT  = 5'd16;

  logic [4:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  led_q, led_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] reg_q [8];
  logic [15:0] reg_d [8];
  logic [15:0] ram_q [MEM_WORDS];
  logic [2:0]  runSync_q, contSync_q;

  logic        runPress, contPress, memWe, writeDr;
  logic [15:0] sr1, sr2, srcStore, operand, result, memRdata;
  logic [15:0] imm5, off6, off9;
  logic        marInRam;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Buttons idle high; a press is a falling edge seen after the two synchronizer flops.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      runSync_q  <= 3'b111;
      contSync_q <= 3'b111;
    end else begin
      runSync_q  <= {runSync_q[1:0], Run};
      contSync_q <= {contSync_q[1:0], Continue};
    end
  end

  assign runPress  = runSync_q[2] & ~runSync_q[1];
  assign contPress = contSync_q[2] & ~contSync_q[1];

  assign sr1      = reg_q[ir_q[8:6]];
  assign sr2      = reg_q[ir_q[2:0]];
  assign srcStore = reg_q[ir_q[11:9]];
  assign imm5     = {{11{ir_q[4]}}, ir_q[4:0]};
  assign off6     = {{10{ir_q[5]}}, ir_q[5:0]};
  assign off9     = {{7{ir_q[8]}}, ir_q[8:0]};
  assign operand  = ir_q[5] ? imm5 : sr2;
  assign marInRam = ({1'b0, mar_q} < MEM_LIMIT);

  always_comb begin
    memRdata = 16'h0000;
    if (mar_q == IO_ADDR) memRdata = {6'b0, SW};
    else if (marInRam)    memRdata = ram_q[mar_q[AW-1:0]];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hex_d   = hex_q;
    led_d   = led_q;
    nzp_d   = nzp_q;
    reg_d   = reg_q;
    memWe   = 1'b0;
    writeDr = 1'b0;
    result  = 16'h0000;
    case (state_q)
      S_HALTED: if (runPress) state_d = S_FETCH1;
      S_FETCH1: begin
        mar_d   = pc_q;
        pc_d    = pc_q + 16'd1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        mdr_d   = memRdata;
        state_d = S_FETCH3;
      end
      S_FETCH3: begin
        ir_d    = mdr_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q[15:12])
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
          4'b1101: state_d = S_PAUSE;
          default: state_d = S_FETCH1;
        endcase
      end
      S_ADD: begin
        result  = sr1 + operand;
        writeDr = 1'b1;
        state_d = S_FETCH1;
      end
      S_AND: begin
        result  = sr1 & operand;
        writeDr = 1'b1;
        state_d = S_FETCH1;
      end
      S_NOT: begin
        result  = ~sr1;
        writeDr = 1'b1;
        state_d = S_FETCH1;
      end
      S_BR: begin
        if ((ir_q[11:9] & nzp_q) != 3'b000) pc_d = pc_q + off9;
        state_d = S_FETCH1;
      end
      S_JMP: begin
        pc_d    = sr1;
        state_d = S_FETCH1;
      end
      S_LDR1: begin
        mar_d   = sr1 + off6;
        state_d = S_LDR2;
      end
      S_LDR2: begin
        mdr_d   = memRdata;
        state_d = S_LDR3;
      end
      S_LDR3: begin
        result  = mdr_q;
        writeDr = 1'b1;
        state_d = S_FETCH1;
      end
      S_STR1: begin
        mar_d   = sr1 + off6;
        mdr_d   = srcStore;
        state_d = S_STR2;
      end
      S_STR2: begin
        if (mar_q == IO_ADDR) hex_d = mdr_q;
        else                  memWe = marInRam;
        state_d = S_FETCH1;
      end
      S_PAUSE: begin
        led_d   = ir_q[9:0];
        state_d = S_PWAIT;
      end
      S_PWAIT: if (contPress) state_d = S_FETCH1;
      default: state_d = S_HALTED;
    endcase
    if (writeDr) begin
      reg_d[ir_q[11:9]] = result;
      nzp_d = result[15] ? 3'b100 : (result == 16'h0000) ? 3'b010 : 3'b001;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_HALTED;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hex_q   <= '0;
      led_q   <= '0;
      nzp_q   <= 3'b010;
      for (int i = 0; i < 8; i++) reg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hex_q   <= hex_d;
      led_q   <= led_d;
      nzp_q   <= nzp_d;
      reg_q   <= reg_d;
    end
  end

  // Reset reloads the echo program: R0=0, R1=[FFFF], [FFFF]=R1, PAUSE 1, BR back to 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < MEM_WORDS; i++) ram_q[i] <= '0;
      ram_q[0] <= 16'h5020;
      ram_q[1] <= 16'h623F;
      ram_q[2] <= 16'h723F;
      ram_q[3] <= 16'hD001;
      ram_q[4] <= 16'h0FFB;
    end else if (memWe) begin
      ram_q[mar_q[AW-1:0]] <= mdr_q;
    end
  end

  assign LED  = led_q;
  assign HEX0 = seg7(hex_q[3:0]);
  assign HEX1 = seg7(hex_q[7:4]);
  assign HEX2 = seg7(hex_q[11:8]);
  assign HEX3 = seg7(hex_q[15:12]);
`ifdef DEBUG_HEX_EN
  assign HEX4 = seg7(pc_q[3:0]);
  assign HEX5 = seg7(pc_q[7:4]);
`else
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

endmodule

// File: tb/tb_slc3_test_top.sv
// Self-checking bench for slc3_test_top: table of switch values echoed through the
// running program, scoreboarded against the hex/LED outputs, plus reset corner cases.
module tb_slc3_test_top;

  typedef struct {
    logic [9:0]  sw;
    logic [15:0] expHex;
  } vec_t;

  typedef struct {
    logic [15:0] hex;
    logic [9:0]  led;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run = 1'b1;
  logic       Continue = 1'b1;
  logic [9:0] SW = '0;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int   nVec = 0;
  int   nMis = 0;
  vec_t vecs[12];
  exp_t sbQueue[$];

  slc3_test_top dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .SW(SW),
    .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] segModel(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic compare(input string name, input logic [9:0] act, input logic [9:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkHex(input string name, input logic [15:0] hexVal, input logic [9:0] ledVal);
    compare({name, ".HEX0"}, {3'b0, HEX0}, {3'b0, segModel(hexVal[3:0])});
    compare({name, ".HEX1"}, {3'b0, HEX1}, {3'b0, segModel(hexVal[7:4])});
    compare({name, ".HEX2"}, {3'b0, HEX2}, {3'b0, segModel(hexVal[11:8])});
    compare({name, ".HEX3"}, {3'b0, HEX3}, {3'b0, segModel(hexVal[15:12])});
    compare({name, ".LED"}, LED, ledVal);
  endtask

  // Press a button for two cycles, then queue what the next PAUSE should show.
  task automatic applyStimulus(input vec_t v, input logic useRun);
    exp_t e;
    SW = v.sw;
    @(negedge Clk);
    if (useRun) Run = 1'b0; else Continue = 1'b0;
    waitCycles(2);
    Run = 1'b1;
    Continue = 1'b1;
    e.hex = v.expHex;
    e.led = 10'h001;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    waitCycles(60);
    if (sbQueue.size() == 0) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL %s: scoreboard empty, got none expected one entry", name);
    end else begin
      e = sbQueue.pop_front();
      checkHex(name, e.hex, e.led);
    end
  endtask

  initial begin
    logic [6:0] expH4, expH5;
    vecs[0]  = '{10'h02A, 16'h002A};
    vecs[1]  = '{10'h3FF, 16'h03FF};
    vecs[2]  = '{10'h000, 16'h0000};
    vecs[3]  = '{10'h155, 16'h0155};
    vecs[4]  = '{10'h2AA, 16'h02AA};
    vecs[5]  = '{10'h001, 16'h0001};
    vecs[6]  = '{10'h200, 16'h0200};
    vecs[7]  = '{10'h0F0, 16'h00F0};
    vecs[8]  = '{10'h30C, 16'h030C};
    vecs[9]  = '{10'h1E5, 16'h01E5};
    vecs[10] = '{10'h3FE, 16'h03FE};
    vecs[11] = '{10'h07B, 16'h007B};

    // Reset then idle without Run: must stay halted showing zeros.
    waitCycles(3);
    checkHex("reset", 16'h0000, 10'h000);
    Reset = 1'b1;
    waitCycles(100);
    checkHex("haltIdle", 16'h0000, 10'h000);
`ifdef DEBUG_HEX_EN
    compare("haltIdle.HEX4", {3'b0, HEX4}, 10'h040);
`else
    compare("haltIdle.HEX4", {3'b0, HEX4}, 10'h07F);
`endif

    // First pass started by Run; PC sits at 4 once paused.
    applyStimulus(vecs[0], 1'b1);
    checkOutput("vec0");
`ifdef DEBUG_HEX_EN
    expH4 = 7'h19;
    expH5 = 7'h40;
`else
    expH4 = 7'h7F;
    expH5 = 7'h7F;
`endif
    compare("pause.HEX4", {3'b0, HEX4}, {3'b0, expH4});
    compare("pause.HEX5", {3'b0, HEX5}, {3'b0, expH5});

    for (int i = 1; i < 12; i++) begin
      applyStimulus(vecs[i], 1'b0);
      if (i % 3 == 0) begin
        waitCycles(5);
        Run = 1'b0;
        waitCycles(2);
        Run = 1'b1;
      end
      checkOutput($sformatf("vec%0d", i));
    end

    // Changing SW while paused must not advance the program.
    SW = 10'h111;
    waitCycles(60);
    checkHex("pauseHold", 16'h007B, 10'h001);

    // Reset is asynchronous: outputs clear before the next clock edge.
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1 checkHex("asyncReset", 16'h0000, 10'h000);
    waitCycles(3);
    Reset = 1'b1;

    // Abort in the STR fetch: the hex register must never be written.
    SW = 10'h155;
    @(negedge Clk);
    Run = 1'b0;
    repeat (16) @(posedge Clk);
    #2 Reset = 1'b0;
    #1 checkHex("strAbort", 16'h0000, 10'h000);
    Run = 1'b1;
    waitCycles(3);
    Reset = 1'b1;
    waitCycles(50);
    checkHex("strAbortHalt", 16'h0000, 10'h000);

    applyStimulus(vecs[3], 1'b1);
    checkOutput("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
